// File: rtl/mem_arbiter.sv
// Shared memory port arbiter for fetch and load/store, one outstanding access.
// Define MEM_ARBITER_RR_EN for round-robin instead of fixed LS priority.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [ADDR_W-1:0] ls_wdata,
  input  logic [3:0]        ls_wmask,
  output logic              ls_gnt,
  output logic              ls_valid,
  output logic [ADDR_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [ADDR_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   drop;
  logic   if_ok;
  logic   pick_ls;
  logic   issue;
  logic   hs;

  assign if_ok = if_req && !flush;

`ifdef MEM_ARBITER_RR_EN
  // ptr=0 favours LS, ptr=1 favours IF on contention
  logic ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (hs) begin
      ptr <= pick_ls;
    end
  end

  assign pick_ls = ls_req && (!if_ok || !ptr);
`else
  assign pick_ls = ls_req;
`endif

  assign issue = !rst && (state == IDLE) && (ls_req || if_ok);
  assign hs    = issue && mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (hs) begin
          state_nx = pick_ls ? BUSY_LS : BUSY_IF;
        end
      end
      BUSY_IF: begin
        if (mem_rvalid) state_nx = IDLE;
      end
      BUSY_LS: begin
        if (mem_rvalid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // a flush seen at any point of a fetch poisons its response
  always_ff @(posedge clk) begin
    if (rst) begin
      drop <= 1'b0;
    end else if (state == BUSY_IF) begin
      drop <= mem_rvalid ? 1'b0 : (drop || flush);
    end else begin
      drop <= 1'b0;
    end
  end

  always_comb begin
    mem_req   = issue;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = 4'b0000;
    if_gnt    = hs && !pick_ls;
    ls_gnt    = hs && pick_ls;
    if_valid  = 1'b0;
    ls_valid  = 1'b0;
    if_rdata  = '0;
    ls_rdata  = '0;
    if (issue) begin
      if (pick_ls) begin
        mem_we    = ls_we;
        mem_addr  = ls_addr;
        mem_wdata = ls_wdata;
        mem_wmask = ls_we ? ls_wmask : 4'b0000;
      end else begin
        mem_addr  = if_addr;
      end
    end
    if (!rst && mem_rvalid) begin
      if (state == BUSY_IF) begin
        if_valid = !drop && !flush;
      end
      if (state == BUSY_LS) begin
        ls_valid = 1'b1;
      end
    end
    if (if_valid) if_rdata = mem_rdata;
    if (ls_valid) ls_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, backpressure, flush, reset.
// Expectations follow MEM_ARBITER_RR_EN when the bench is built with it.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_wmask;
  logic        ls_gnt;
  logic        ls_valid;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_gnt(ls_gnt),
    .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_gnt"}, {30'd0, if_gnt, ls_gnt}, 32'd0);
    chk({tag, "_vld"}, {30'd0, if_valid, ls_valid}, 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_rd"}, if_rdata | ls_rdata, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0;
    ls_wdata = '0; ls_wmask = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;

    // request held during reset must not issue
    @(negedge clk);
    all_zero("in_rst");
    tick;
    tick;
    rst = 1'b0; if_req = 1'b0;
    @(negedge clk);
    all_zero("post_rst");
    tick;

    // single fetch
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    chk("f_req", {31'd0, mem_req}, 32'd1);
    chk("f_addr", mem_addr, 32'h100);
    chk("f_we", {27'd0, mem_we, mem_wmask}, 32'd0);
    chk("f_gnt", {30'd0, if_gnt, ls_gnt}, 32'b10);
    tick;
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h13;
    @(negedge clk);
    chk("f_vld", {30'd0, if_valid, ls_valid}, 32'b10);
    chk("f_rd", if_rdata, 32'h13);
    chk("f_busy_req", {31'd0, mem_req}, 32'd0);
    tick;

    // stray response in IDLE
    @(negedge clk);
    chk("idle_rv_vld", {30'd0, if_valid, ls_valid}, 32'd0);
    chk("idle_rv_rd", if_rdata | ls_rdata, 32'd0);
    tick;
    mem_rvalid = 1'b0;

    // contention: LS store first
    if_req = 1'b1; if_addr = 32'h180;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2000;
    ls_wdata = 32'hDEADBEEF; ls_wmask = 4'hF;
    @(negedge clk);
    chk("c1_gnt", {30'd0, if_gnt, ls_gnt}, 32'b01);
    chk("c1_addr", mem_addr, 32'h2000);
    chk("c1_we", {27'd0, mem_we, mem_wmask}, 32'h1F);
    chk("c1_wd", mem_wdata, 32'hDEADBEEF);
    tick;
    mem_rvalid = 1'b1; mem_rdata = 32'h0;
    @(negedge clk);
    chk("c1_ack", {30'd0, if_valid, ls_valid}, 32'b01);
    chk("c1_noiss", {29'd0, mem_req, if_gnt, ls_gnt}, 32'd0);
    tick;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("c2_gnt", {30'd0, if_gnt, ls_gnt}, RR ? 32'b10 : 32'b01);
    chk("c2_addr", mem_addr, RR ? 32'h180 : 32'h2000);
    tick;
    ls_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0033;
    @(negedge clk);
    chk("c2_vld", {30'd0, if_valid, ls_valid}, RR ? 32'b10 : 32'b01);
    tick;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("c3_gnt", {30'd0, if_gnt, ls_gnt}, 32'b10);
    tick;
    if_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0073;
    @(negedge clk);
    chk("c3_rd", if_rdata, 32'h73);
    tick;
    mem_rvalid = 1'b0;

    // backpressure
    if_req = 1'b1; if_addr = 32'h300; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_req", {31'd0, mem_req}, 32'd1);
      chk("bp_addr", mem_addr, 32'h300);
      chk("bp_gnt", {30'd0, if_gnt, ls_gnt}, 32'd0);
      tick;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("bp_gnt3", {30'd0, if_gnt, ls_gnt}, 32'b10);
    tick;
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55;
    @(negedge clk);
    chk("bp_rd", if_rdata, 32'h55);
    tick;
    mem_rvalid = 1'b0;

    // flush blocks fetch in IDLE but not LS
    flush = 1'b1; if_req = 1'b1;
    @(negedge clk);
    chk("fl_idle", {31'd0, mem_req}, 32'd0);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h44;
    #1;
    chk("fl_ls", {30'd0, if_gnt, ls_gnt}, 32'b01);
    tick;
    ls_req = 1'b0; if_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h99;
    @(negedge clk);
    chk("fl_lsv", ls_rdata, 32'h99);
    tick;
    mem_rvalid = 1'b0; flush = 1'b0;

    // flush during fetch drops the response
    if_req = 1'b1; if_addr = 32'h104;
    @(negedge clk);
    chk("fd_gnt", {30'd0, if_gnt, ls_gnt}, 32'b10);
    tick;
    if_req = 1'b0; flush = 1'b1;
    tick;
    flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA;
    @(negedge clk);
    chk("fd_vld", {31'd0, if_valid}, 32'd0);
    chk("fd_rd", if_rdata, 32'd0);
    tick;
    mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h200;
    @(negedge clk);
    chk("fd2_gnt", {30'd0, if_gnt, ls_gnt}, 32'b10);
    chk("fd2_addr", mem_addr, 32'h200);
    tick;
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    chk("fd2_vld", {31'd0, if_valid}, 32'd1);
    chk("fd2_rd", if_rdata, 32'h0050_0093);
    tick;
    mem_rvalid = 1'b0;

    // reset during a load
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40; ls_wmask = 4'hF;
    @(negedge clk);
    chk("rm_gnt", {30'd0, if_gnt, ls_gnt}, 32'b01);
    chk("rm_mask", {28'd0, mem_wmask}, 32'd0);
    tick;
    ls_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    all_zero("rm_rst");
    tick;
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234;
    @(negedge clk);
    all_zero("rm_late");
    tick;
    mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h400;
    @(negedge clk);
    chk("rm_idle", {30'd0, if_gnt, mem_req}, 32'b11);
    tick;
    if_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32 (XLEN), width of every address and data bus.
REQ-002 SHALL have ports, one per line:
 clk  in  1  sole clock, rising edge
 rst  in  1  synchronous reset, active-high
 flush  in  1  pipeline flush from branch/jump resolution
 if_req  in  1  fetch unit requests instruction word
 if_addr  in  32  fetch address (pc)
 if_gnt  out  1  fetch request accepted by memory this cycle
 if_valid  out  1  fetched word valid this cycle
 if_rdata  out  32  fetched instruction word
 ls_req  in  1  load/store unit request
 ls_we  in  1  1=store, 0=load
 ls_addr  in  32  load/store address
 ls_wdata  in  32  store data
 ls_wmask  in  4  store byte enables
 ls_gnt  out  1  ls request accepted this cycle
 ls_valid  out  1  ls transaction complete (load data or store ack)
 ls_rdata  out  32  load data
 mem_req  out  1  request to shared memory port
 mem_we  out  1  write enable to memory
 mem_addr  out  32  memory address
 mem_wdata  out  32  write data
 mem_wmask  out  4  byte enables (4'b0000 on reads)
 mem_ready  in  1  memory accepts mem_req this cycle
 mem_rvalid  in  1  memory response valid (read data or write ack)
 mem_rdata  in  32  memory read data

Function
REQ-003 SHALL implement FSM states IDLE, BUSY_IF, BUSY_LS; at most one outstanding memory transaction.
REQ-004 In IDLE with any request, SHALL drive mem_req=1 combinationally with selected requester's addr/we/wdata/wmask; IF selection drives mem_we=0, mem_wmask=0.
REQ-005 Selection SHALL be fixed priority LS over IF when both request (unless REQ-017 macro defined).
REQ-006 In IDLE, if_req SHALL be ignored in any cycle flush=1.
REQ-007 Handshake: selected gnt SHALL pulse 1 only in the cycle mem_req=1 and mem_ready=1; FSM SHALL move to BUSY_IF/BUSY_LS on that edge; without mem_ready, FSM stays IDLE and selection is re-evaluated next cycle.
REQ-008 In BUSY_x, mem_req SHALL be 0; on mem_rvalid=1, x_valid SHALL pulse 1 for one cycle with x_rdata=mem_rdata (combinational pass-through), and FSM SHALL return to IDLE; no new issue in that cycle (minimum 2 cycles per transaction).
REQ-009 if_rdata/ls_rdata SHALL be 0 whenever the corresponding valid is 0.
REQ-010 mem_rvalid in IDLE SHALL be ignored (no valid output).
REQ-011 flush=1 in BUSY_IF (including the rvalid cycle) SHALL set a drop flag; the completing response SHALL then produce if_valid=0, drop flag cleared on return to IDLE.
REQ-012 flush SHALL NOT affect LS grants, BUSY_LS, or ls_valid.
REQ-013 Simultaneous mem_rvalid and new requests SHALL complete the response only; requests served from the following cycle.

Reset
REQ-014 rst=1 at a clock edge SHALL force IDLE, clear drop flag and round-robin pointer (pointer selects LS first).
REQ-015 During and in the cycle after reset, all outputs SHALL be 0 unless a request is presented after rst deasserts.
REQ-016 Reset mid-transaction SHALL abandon it; a late mem_rvalid lands in IDLE and is ignored per REQ-010.

Configuration
REQ-017 Macro MEM_ARBITER_RR_EN: defined -> when both request in IDLE, grant alternates; pointer toggles to the other requester after each grant; undefined -> fixed LS priority per REQ-005, no pointer register.

Verification
REQ-018 Single fetch: if_req=1, if_addr=0x100, mem_ready=1, mem_rvalid next cycle with mem_rdata=0x00000013 -> if_gnt pulse cycle 0, if_valid=1, if_rdata=0x13 cycle 1.
REQ-019 Contention: if_req=ls_req=1 held, ls_we=1, ls_addr=0x2000, ls_wdata=0xDEADBEEF, ls_wmask=0xF -> LS granted first, mem_we=1, ls_valid on ack; fixed mode IF served after; RR mode strictly alternates LS,IF,LS,IF over 4 transactions.
REQ-020 Backpressure: mem_ready=0 for 3 cycles -> mem_req held, mem_addr stable, no gnt until cycle 3.
REQ-021 Flush: fetch 0x104 granted, flush=1 one cycle later, rvalid 2 cycles later -> if_valid stays 0, FSM back to IDLE, next fetch 0x200 completes normally.
REQ-022 Reset mid-op: rst in BUSY_LS, mem_rvalid=1 the next cycle -> ls_valid=0, all outputs 0, FSM IDLE.
